// File: rtl/srec_pkg.sv
// Shared definitions for the S-record memory writer: parser state encoding,
// record kinds, error codes and the ASCII characters the parser recognises.
package srec_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TYPE,
    ST_COUNT,
    ST_ADDR,
    ST_DATA,
    ST_CKSUM,
    ST_ERROR,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    REC_S0,
    REC_S1,
    REC_S9
  } rec_t;

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_START = 3'd1;
  localparam logic [2:0] ERR_TYPE  = 3'd2;
  localparam logic [2:0] ERR_HEX   = 3'd3;
  localparam logic [2:0] ERR_COUNT = 3'd4;
  localparam logic [2:0] ERR_CKSUM = 3'd5;

  localparam logic [7:0] ASCII_S  = 8'h53;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_SP = 8'h20;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_1  = 8'h31;
  localparam logic [7:0] ASCII_9  = 8'h39;

  // Characters silently skipped between records.
  function automatic logic is_blank(input logic [7:0] c);
    return (c == ASCII_CR) || (c == ASCII_LF) || (c == ASCII_SP);
  endfunction

endpackage

// File: rtl/hex_ascii_decode.sv
// Combinational ASCII hex digit decoder.
// Ports:
//   char_i    in  8  ASCII character
//   valid_o   out 1  character is 0-9, A-F or a-f
//   nibble_o  out 4  decoded value (0 when not valid)
module hex_ascii_decode (
  input  logic [7:0] char_i,
  output logic       valid_o,
  output logic [3:0] nibble_o
);

  always_comb begin
    valid_o  = 1'b1;
    nibble_o = '0;
    if (char_i >= 8'h30 && char_i <= 8'h39) begin
      nibble_o = char_i[3:0];
    end else if ((char_i >= 8'h41 && char_i <= 8'h46) ||
                 (char_i >= 8'h61 && char_i <= 8'h66)) begin
      // 'A'/'a' have low nibble 1, so +9 maps them to 10.
      nibble_o = char_i[3:0] + 4'd9;
    end else begin
      valid_o = 1'b0;
    end
  end

endmodule

// File: rtl/srec_mem_writer.sv
// Motorola S-record (S0/S1/S9) loader: parses an ASCII byte stream, writes
// S1 data bytes into a byte memory, verifies each record checksum and
// captures the S9 entry address.
// Ports:
//   Clock       in   1       rising-edge clock
//   Reset_n     in   1       synchronous active-low reset
//   rx_data     in   8       ASCII character
//   rx_valid    in   1       one-cycle strobe qualifying rx_data
//   mem_addr    out  ADDR_W  write address (holds when mem_we=0)
//   mem_wdata   out  DATA_W  write data (holds when mem_we=0)
//   mem_we      out  1       one-cycle write strobe
//   entry_addr  out  16      S9 entry address
//   rec_count   out  16      S1 records with a good checksum (wraps)
//   busy        out  1       inside a record
//   done        out  1       sticky, valid S9 received
//   error       out  1       sticky, parse/checksum failure
//   err_code    out  3       failure cause
module srec_mem_writer
  import srec_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic [15:0]       entry_addr,
  output logic [15:0]       rec_count,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [2:0]        err_code
);

  state_t            state_q;
  rec_t              rec_q;
  logic [1:0]        dig_q;       // digit index within the current field
  logic [3:0]        hi_q;        // high nibble of the byte being assembled
  logic [7:0]        cnt_q;
  logic [7:0]        rem_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        chk_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [15:0]       entry_q;
  logic [15:0]       rec_cnt_q;
  logic              busy_q;
  logic              done_q;
  logic              error_q;
  logic [2:0]        err_code_q;

  logic       hex_ok;
  logic [3:0] nib;
  logic [7:0] byte_w;
  logic [7:0] ck_sum;
  logic       in_field;

  hex_ascii_decode u_hex (
    .char_i   (rx_data),
    .valid_o  (hex_ok),
    .nibble_o (nib)
  );

  always_comb begin
    byte_w   = {hi_q, nib};
    ck_sum   = chk_q + byte_w;
    in_field = (state_q == ST_COUNT) || (state_q == ST_ADDR) ||
               (state_q == ST_DATA)  || (state_q == ST_CKSUM);
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q     <= ST_IDLE;
      rec_q       <= REC_S0;
      dig_q       <= '0;
      hi_q        <= '0;
      cnt_q       <= '0;
      rem_q       <= '0;
      addr_q      <= '0;
      chk_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      entry_q     <= '0;
      rec_cnt_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      mem_we_q <= 1'b0;
      if (rx_valid) begin
        // Bad digit check is shared by every hex field state.
        if (in_field && !hex_ok) begin
          state_q    <= ST_ERROR;
          error_q    <= 1'b1;
          err_code_q <= ERR_HEX;
          busy_q     <= 1'b0;
        end else begin
          unique case (state_q)
            ST_IDLE: begin
              if (rx_data == ASCII_S) begin
                state_q <= ST_TYPE;
                busy_q  <= 1'b1;
              end else if (!is_blank(rx_data)) begin
                state_q    <= ST_ERROR;
                error_q    <= 1'b1;
                err_code_q <= ERR_START;
              end
            end

            ST_TYPE: begin
              dig_q <= '0;
              chk_q <= '0;
              if (rx_data == ASCII_0) begin
                rec_q   <= REC_S0;
                state_q <= ST_COUNT;
              end else if (rx_data == ASCII_1) begin
                rec_q   <= REC_S1;
                state_q <= ST_COUNT;
              end else if (rx_data == ASCII_9) begin
                rec_q   <= REC_S9;
                state_q <= ST_COUNT;
              end else begin
                state_q    <= ST_ERROR;
                error_q    <= 1'b1;
                err_code_q <= ERR_TYPE;
                busy_q     <= 1'b0;
              end
            end

            ST_COUNT: begin
              if (!dig_q[0]) begin
                hi_q  <= nib;
                dig_q <= 2'd1;
              end else begin
                dig_q <= '0;
                cnt_q <= byte_w;
                chk_q <= byte_w;
                if (byte_w < 8'd3) begin
                  state_q    <= ST_ERROR;
                  error_q    <= 1'b1;
                  err_code_q <= ERR_COUNT;
                  busy_q     <= 1'b0;
                end else begin
                  state_q <= ST_ADDR;
                end
              end
            end

            ST_ADDR: begin
              addr_q <= {addr_q[ADDR_W-5:0], nib};
              dig_q  <= dig_q + 2'd1;
              if (!dig_q[0]) begin
                hi_q <= nib;
              end else begin
                chk_q <= ck_sum;
              end
              if (dig_q == 2'd3) begin
                rem_q   <= cnt_q - 8'd3;
                state_q <= (cnt_q == 8'd3) ? ST_CKSUM : ST_DATA;
              end
            end

            ST_DATA: begin
              if (!dig_q[0]) begin
                hi_q  <= nib;
                dig_q <= 2'd1;
              end else begin
                dig_q <= '0;
                chk_q <= ck_sum;
                rem_q <= rem_q - 8'd1;
                if (rec_q == REC_S1) begin
                  mem_we_q    <= 1'b1;
                  mem_addr_q  <= addr_q;
                  mem_wdata_q <= DATA_W'(byte_w);
                  addr_q      <= addr_q + ADDR_W'(1);
                end
                if (rem_q == 8'd1) begin
                  state_q <= ST_CKSUM;
                end
              end
            end

            ST_CKSUM: begin
              if (!dig_q[0]) begin
                hi_q  <= nib;
                dig_q <= 2'd1;
              end else begin
                dig_q  <= '0;
                busy_q <= 1'b0;
                if (ck_sum != 8'hFF) begin
                  state_q    <= ST_ERROR;
                  error_q    <= 1'b1;
                  err_code_q <= ERR_CKSUM;
                end else if (rec_q == REC_S1) begin
                  rec_cnt_q <= rec_cnt_q + 16'd1;
                  state_q   <= ST_IDLE;
                end else if (rec_q == REC_S9) begin
                  entry_q <= addr_q[15:0];
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
                end else begin
                  state_q <= ST_IDLE;
                end
              end
            end

            default: begin
              // ST_ERROR / ST_DONE: frozen until reset.
            end
          endcase
        end
      end
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_we     = mem_we_q;
  assign entry_addr = entry_q;
  assign rec_count  = rec_cnt_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign err_code   = err_code_q;

endmodule

// File: tb/tb_srec_mem_writer.sv
// Self-checking bench for srec_mem_writer: directed records followed by
// randomly generated records whose expected effects are derived from how
// each record was constructed.
module tb_srec_mem_writer;

  logic        Clock    = 1'b0;
  logic        Reset_n  = 1'b0;
  logic [7:0]  rx_data  = '0;
  logic        rx_valid = 1'b0;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [15:0] entry_addr;
  logic [15:0] rec_count;
  logic        busy;
  logic        done;
  logic        error;
  logic [2:0]  err_code;

  srec_mem_writer #(.ADDR_W(16), .DATA_W(8)) dut (
    .Clock      (Clock),
    .Reset_n    (Reset_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .entry_addr (entry_addr),
    .rec_count  (rec_count),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .err_code   (err_code)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    int          idx;
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t         got_q[$];
  wr_t         exp_q[$];
  logic [7:0]  rec[$];
  logic [7:0]  dat[$];
  int          cidx  = 0;
  int          n_vec = 0;
  int          n_bad = 0;

  logic [15:0] m_rc, m_entry;
  logic        m_done, m_err;
  logic [2:0]  m_code;

  logic [7:0] blanks[3]  = '{8'h0D, 8'h0A, 8'h20};
  logic [7:0] bad_typ[4] = '{8'h32, 8'h35, 8'h58, 8'h73};
  logic [7:0] bad_st[4]  = '{8'h58, 8'h23, 8'h31, 8'h73};
  logic [7:0] bad_hex[4] = '{8'h47, 8'h67, 8'h3A, 8'h20};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Writes are captured on the falling edge together with the index of
  // the character whose strobe preceded them.
  always @(negedge Clock) begin
    if (mem_we === 1'b1) got_q.push_back('{cidx, mem_addr, mem_wdata});
  end

  task automatic send_char(input logic [7:0] c);
    @(negedge Clock);
    cidx++;
    rx_data  = c;
    rx_valid = 1'b1;
    @(negedge Clock);
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  task automatic send_rec();
    foreach (rec[i]) send_char(rec[i]);
  endtask

  task automatic exp_wr(input int idx, input logic [15:0] a, input logic [7:0] d);
    exp_q.push_back('{idx, a, d});
  endtask

  task automatic model_clear();
    m_rc = '0; m_entry = '0; m_done = 1'b0; m_err = 1'b0; m_code = '0;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge Clock);
    Reset_n  = 1'b0;
    rx_valid = 1'b0;
    @(negedge Clock);
    @(negedge Clock);
    check_val("rst.addr",  mem_addr,  32'h0);
    check_val("rst.wdata", mem_wdata, 32'h0);
    check_val("rst.rc",    rec_count, 32'h0);
    check_val("rst.flags", {mem_we, busy, done, error, err_code, entry_addr}, 32'h0);
    Reset_n = 1'b1;
    model_clear();
  endtask

  task automatic check_rec(input string tag);
    repeat (2) @(negedge Clock);
    check_val({tag, ".nwr"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check_val({tag, ".widx"},  got_q[i].idx, exp_q[i].idx);
      check_val({tag, ".waddr"}, got_q[i].a,   exp_q[i].a);
      check_val({tag, ".wdata"}, got_q[i].d,   exp_q[i].d);
    end
    check_val({tag, ".err"},   error,      m_err);
    check_val({tag, ".code"},  err_code,   m_code);
    check_val({tag, ".done"},  done,       m_done);
    check_val({tag, ".entry"}, entry_addr, m_entry);
    check_val({tag, ".rc"},    rec_count,  m_rc);
    if (!m_err) check_val({tag, ".busy"}, busy, 0);
    got_q.delete();
    exp_q.delete();
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return (($urandom_range(1) == 1) ? 8'h61 : 8'h41) + {4'h0, n} - 8'd10;
  endfunction

  task automatic put_byte(input logic [7:0] b);
    rec.push_back(hexc(b[7:4]));
    rec.push_back(hexc(b[3:0]));
  endtask

  // Builds a record with random data; ckx!=0 corrupts the checksum.
  task automatic build_rec(input logic [7:0] tch, input logic [15:0] a,
                           input int nd, input logic [7:0] ckx);
    logic [7:0] cnt, sum;
    dat.delete();
    rec.delete();
    cnt = 8'(nd + 3);
    sum = cnt + a[15:8] + a[7:0];
    for (int k = 0; k < nd; k++) begin
      dat.push_back(8'($urandom));
      sum = sum + dat[k];
    end
    rec.push_back(8'h53);
    rec.push_back(tch);
    put_byte(cnt);
    put_byte(a[15:8]);
    put_byte(a[7:0]);
    foreach (dat[k]) put_byte(dat[k]);
    put_byte(~sum ^ ckx);
  endtask

  // Data byte k's second digit sits at record position 9+2k.
  task automatic exp_data(input int base, input logic [15:0] a, input int upto);
    foreach (dat[k]) if (9 + 2 * k < upto) exp_wr(base + 10 + 2 * k, a + 16'(k), dat[k]);
  endtask

  initial begin
    int          base, kind, nd, p;
    logic [15:0] a;

    model_clear();
    do_reset();

    // Basic S1 record with trailing CR/LF.
    base = cidx;
    send_str("S1050010ABCD72\r\n");
    exp_wr(base + 10, 16'h0010, 8'hAB);
    exp_wr(base + 12, 16'h0011, 8'hCD);
    m_rc = 16'd1;
    check_rec("t1");

    // Reset in the middle of a record, then a clean record.
    send_str("S10500");
    check_val("t6.busy", busy, 1);
    do_reset();
    base = cidx;
    send_str("S1050010ABCD72");
    exp_wr(base + 10, 16'h0010, 8'hAB);
    exp_wr(base + 12, 16'h0011, 8'hCD);
    m_rc = 16'd1;
    check_rec("t6");

    // Bad checksum: writes stay, error sticks, further input ignored.
    do_reset();
    base = cidx;
    send_str("S1050010ABCD73");
    exp_wr(base + 10, 16'h0010, 8'hAB);
    exp_wr(base + 12, 16'h0011, 8'hCD);
    send_str("S1050020ABCD62");
    m_err = 1'b1; m_code = 3'd5;
    check_rec("t2");

    // S9 entry address, then frozen.
    do_reset();
    send_str("S9030100FB");
    send_str("S1050010ABCD72");
    m_done = 1'b1; m_entry = 16'h0100;
    check_rec("t3");

    // Address wrap source, lowercase digits, bad hex digit.
    do_reset();
    base = cidx;
    send_str("S104FFFF12EB");
    exp_wr(base + 10, 16'hFFFF, 8'h12);
    base = cidx;
    send_str("S1050010ABcd72");
    exp_wr(base + 10, 16'h0010, 8'hAB);
    exp_wr(base + 12, 16'h0011, 8'hCD);
    m_rc = 16'd2;
    check_rec("t4a");
    send_str("S1050010AGCD72");
    m_err = 1'b1; m_code = 3'd3;
    check_rec("t4b");

    // Bad start, bad type, short count.
    do_reset();
    send_str("X");
    m_err = 1'b1; m_code = 3'd1;
    check_rec("t5a");
    do_reset();
    send_str("S5");
    m_err = 1'b1; m_code = 3'd2;
    check_rec("t5b");
    do_reset();
    send_str("S10200");
    m_err = 1'b1; m_code = 3'd4;
    check_rec("t5c");
    do_reset();

    // Random records.
    for (int r = 0; r < 70; r++) begin
      kind = $urandom_range(9);
      nd   = $urandom_range(6);
      a    = ($urandom_range(3) == 0) ? 16'hFFFF - 16'($urandom_range(3)) : 16'($urandom);
      if ($urandom_range(1) == 1) send_char(blanks[$urandom_range(2)]);
      base = cidx;
      case (kind)
        0, 1, 2, 3: begin
          build_rec(8'h31, a, nd, 8'h00);
          exp_data(base, a, rec.size());
          m_rc = m_rc + 16'd1;
          send_rec();
          check_rec("r.s1");
        end
        4: begin
          build_rec(8'h30, a, nd, 8'h00);
          send_rec();
          check_rec("r.s0");
        end
        5: begin
          build_rec(8'h31, a, nd, 8'($urandom_range(255, 1)));
          exp_data(base, a, rec.size());
          m_err = 1'b1; m_code = 3'd5;
          send_rec();
          build_rec(8'h31, a, 2, 8'h00);
          send_rec();
          check_rec("r.ck");
          do_reset();
        end
        6: begin
          build_rec(8'h31, a, nd, 8'h00);
          p = $urandom_range(rec.size() - 1, 2);
          rec[p] = bad_hex[$urandom_range(3)];
          exp_data(base, a, p);
          m_err = 1'b1; m_code = 3'd3;
          send_rec();
          check_rec("r.hex");
          do_reset();
        end
        7: begin
          build_rec(8'h39, a, 0, 8'h00);
          m_done = 1'b1; m_entry = a;
          send_rec();
          check_rec("r.s9");
          build_rec(8'h31, a, 2, 8'h00);
          send_rec();
          check_rec("r.frz");
          do_reset();
        end
        8: begin
          if ($urandom_range(1) == 1) begin
            send_char(8'h53);
            send_char(bad_typ[$urandom_range(3)]);
            m_code = 3'd2;
          end else begin
            send_char(bad_st[$urandom_range(3)]);
            m_code = 3'd1;
          end
          m_err = 1'b1;
          check_rec("r.st");
          do_reset();
        end
        default: begin
          send_char(8'h53);
          send_char(8'h31);
          send_char(8'h30);
          send_char(hexc(4'($urandom_range(2))));
          m_err = 1'b1; m_code = 3'd4;
          check_rec("r.cnt");
          do_reset();
        end
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
